// File: rtl/cronos_ctrl.sv
// -----------------------------------------------------------------------------
// cronos_ctrl
//
// Run/pause/lap controller for the four-digit chronometer. Sits between the
// board push-buttons and the seconds/minutes counter chain and decides when
// the counters advance, clear, or when the display freezes on a lap value.
//
// Build option:
//   CRONOS_DEBOUNCE_EN  defined   -> per-button debounce counter is present
//                       undefined -> conditioned level is the synchroniser
//                                    output (DEB_CYCLES unused)
//
// Parameters:
//   TICK_DIV    osc_clk cycles per counter tick (>= 2)
//   DEB_CYCLES  consecutive stable samples to accept a button change (>= 1)
//
// Ports:
//   osc_clk    in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   btn_start  in   raw start/stop button (asynchronous)
//   btn_lap    in   raw lap/clear button (asynchronous)
//   cnt_en     out  one-cycle pulse advancing the units-of-seconds counter
//   cnt_clr    out  one-cycle pulse clearing all four digit counters
//   disp_hold  out  1 = display shows the frozen lap value
//   state      out  IDLE=00, RUN=01, PAUSE=10, LAP=11
// -----------------------------------------------------------------------------
module cronos_ctrl #(
   parameter int TICK_DIV   = 50_000_000,
   parameter int DEB_CYCLES = 500_000
) (
   input  logic       osc_clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic [1:0] state
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   // Reject parameter values the prescaler and debouncer cannot honour.
   generate
      if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_params
         $error("cronos_ctrl: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
      end
   endgenerate

   // Button vectors use bit 0 for start and bit 1 for lap throughout.
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] level;
   logic [1:0] prev_q, prev_d;
   logic [1:0] press;
   logic       press_start;
   logic       press_lap;

   state_t               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic                 cnt_clr_q, cnt_clr_d;
   logic                 counting_q;
   logic                 counting_d;

   // Two-flop synchroniser: the raw buttons are asynchronous to osc_clk, so
   // nothing downstream looks at them before two register stages.
   always_comb begin
      sync1_d = {btn_lap, btn_start};
      sync2_d = sync1_q;
   end

`ifdef CRONOS_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [1:0]            level_q, level_d;
   logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

   // Debouncer: the accepted level only follows the synchronised sample once
   // it has disagreed with the accepted level for DEB_CYCLES consecutive
   // samples. Any agreeing sample restarts the count, so short bounces die here.
   always_comb begin
      level_d   = level_q;
      deb_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != level_q[i]) begin
            if (deb_cnt_q[i] == DEB_LAST) begin
               level_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   assign level = level_q;
`else
   // Already-clean inputs: the synchroniser output is the conditioned level.
   assign level = sync2_q;
`endif

   // Rising-edge detect on the conditioned level. Releases are ignored and a
   // held button yields one press because prev_q catches up after one cycle.
   // When both buttons press together, start wins and lap is dropped.
   always_comb begin
      prev_d      = level;
      press       = level & ~prev_q;
      press_start = press[0];
      press_lap   = press[1] & ~press[0];
   end

   // Next-state logic for the run/pause/lap sequencer.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (press_start) state_d = RUN;
         end
         RUN: begin
            if (press_start)    state_d = PAUSE;
            else if (press_lap) state_d = LAP;
         end
         LAP: begin
            if (press_start)    state_d = PAUSE;
            else if (press_lap) state_d = RUN;
         end
         PAUSE: begin
            if (press_start)    state_d = RUN;
            else if (press_lap) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Prescaler and clear pulse. The prescaler only advances when the timer
   // is counting both before and after the edge; on the edge into PAUSE and
   // on the resume edge it holds, so a pause taken right on the terminal
   // count keeps TICK_DIV-1 and fires cnt_en again on the first RUN cycle.
   // Entering IDLE zeroes the phase. cnt_clr is registered so it lines up
   // with the first cycle in which state reads IDLE after PAUSE.
   always_comb begin
      counting_q = (state_q == RUN) || (state_q == LAP);
      counting_d = (state_d == RUN) || (state_d == LAP);
      presc_d    = presc_q;
      if (state_d == IDLE) begin
         presc_d = '0;
      end else if (counting_q && counting_d) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
         end else begin
            presc_d = presc_q + PRESC_W'(1);
         end
      end
      cnt_clr_d = (state_q == PAUSE) && (state_d == IDLE);
   end

   // Outputs are decoded from registers only, so nothing here depends
   // combinationally on the buttons.
   always_comb begin
      cnt_en    = ((state_q == RUN) || (state_q == LAP)) && (presc_q == PRESC_LAST);
      cnt_clr   = cnt_clr_q;
      disp_hold = (state_q == LAP);
      state     = state_q;
   end

   // State register: every flop clears on reset, which therefore overrides
   // any press or tick in the same cycle.
   always_ff @(posedge osc_clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         state_q   <= IDLE;
         presc_q   <= '0;
         cnt_clr_q <= 1'b0;
`ifdef CRONOS_DEBOUNCE_EN
         level_q   <= '0;
         deb_cnt_q <= '0;
`endif
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         presc_q   <= presc_d;
         cnt_clr_q <= cnt_clr_d;
`ifdef CRONOS_DEBOUNCE_EN
         level_q   <= level_d;
         deb_cnt_q <= deb_cnt_d;
`endif
      end
   end

endmodule
